// File: rtl/move_collector_if.sv
// Column-FIFO and move-stream bundle for move_collector.
// master: the collector (reads column FIFOs, drives the move stream).
// slave : the environment (column units and the downstream consumer).
interface move_collector_if #(
  parameter int NCOL  = 8,
  parameter int MOVEW = 19,
  parameter int SLOTS = 8
);
  localparam int WORDW = SLOTS * MOVEW;

  logic [NCOL-1:0]       col_done;
  logic [NCOL-1:0]       col_empty;
  logic [NCOL*WORDW-1:0] col_data;
  logic [NCOL-1:0]       col_rden;

  // Move stream: a transfer happens on a rising clk edge where move_valid and
  // move_ready are both high; while move_valid is high and move_ready is low,
  // move is held stable.
  logic [MOVEW-1:0]      move;
  logic                  move_valid;
  logic                  move_ready;

  modport master (
    input  col_done, col_empty, col_data, move_ready,
    output col_rden, move, move_valid
  );

  modport slave (
    output col_done, col_empty, col_data, move_ready,
    input  col_rden, move, move_valid
  );
endinterface

// File: rtl/move_collector.sv
// move_collector: round-robin drain of the column move FIFOs into one serial
// move stream with a saturating move counter and a completion flag.
// Optional feature macro: MOVE_COLLECT_FILTER_EN (drop slots whose invalid
// flag, the MSB of the move, is set; otherwise every slot is presented).
module move_collector #(
  parameter int NCOL  = 8,
  parameter int MOVEW = 19,
  parameter int SLOTS = 8
) (
  input  logic                clk,
  input  logic                reset,      // asynchronous, active-low
  input  logic                start,
  move_collector_if.master    bus,
  output logic [7:0]          move_count,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  localparam int WORDW = SLOTS * MOVEW;
  localparam int PTRW  = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int SLOTW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int INVB  = MOVEW - 1;

`ifdef MOVE_COLLECT_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_READ   = 3'd2,
    S_LATCH  = 3'd3,
    S_UNPACK = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [PTRW-1:0]   sel_q, sel_d;
  logic [WORDW-1:0]  word_q, word_d;
  logic [SLOTW-1:0]  slot_q, slot_d;
  logic [MOVEW-1:0]  move_q, move_d;
  logic              mv_q, mv_d;
  logic [NCOL-1:0]   rden_q, rden_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              found;
  logic [PTRW-1:0]   pick;
  int                idx;
  logic [WORDW-1:0]  cur_word;
  logic [MOVEW-1:0]  next_move;
  logic              last_slot;

  // A slot is presented unless filtering is enabled and its invalid flag is set.
  function automatic logic slot_present(input logic [MOVEW-1:0] m);
    return !(FILTER && m[INVB]);
  endfunction

  assign cur_word  = bus.col_data[int'(sel_q)*WORDW +: WORDW];
  assign last_slot = (slot_q == SLOTW'(SLOTS-1));
  assign next_move = last_slot ? '0 : word_q[(int'(slot_q)+1)*MOVEW +: MOVEW];

  // Round-robin pick: first non-empty column at or after ptr, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NCOL; i++) begin
      idx = (int'(ptr_q) + i) % NCOL;
      if (!found && !bus.col_empty[idx]) begin
        found = 1'b1;
        pick  = PTRW'(idx);
      end
    end
  end

  // Next-state and registered-output computation; start outside IDLE/FIN aborts.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    word_d  = word_q;
    slot_d  = slot_q;
    move_d  = move_q;
    mv_d    = mv_q;
    rden_d  = '0;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d = S_SCAN;
          cnt_d   = '0;
          ptr_d   = '0;
        end
      end
      S_SCAN: begin
        if ((&bus.col_done) && (&bus.col_empty)) begin
          state_d = S_FIN;
        end else if (found) begin
          sel_d   = pick;
          rden_d  = NCOL'(1) << pick;
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // FIFO data for the column read last cycle is on col_data now.
        word_d  = cur_word;
        slot_d  = '0;
        move_d  = cur_word[MOVEW-1:0];
        mv_d    = slot_present(cur_word[MOVEW-1:0]);
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        // A non-presented slot retires in one cycle; a presented one on transfer.
        if (!mv_q || bus.move_ready) begin
          if (mv_q && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
          if (last_slot) begin
            mv_d    = 1'b0;
            ptr_d   = PTRW'((int'(sel_q) + 1) % NCOL);
            state_d = S_SCAN;
          end else begin
            slot_d  = slot_q + SLOTW'(1);
            move_d  = next_move;
            mv_d    = slot_present(next_move);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start && (state_q != S_IDLE) && (state_q != S_FIN)) begin
      state_d = S_SCAN;
      cnt_d   = '0;
      ptr_d   = '0;
      mv_d    = 1'b0;
      rden_d  = '0;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      word_q  <= '0;
      slot_q  <= '0;
      move_q  <= '0;
      mv_q    <= 1'b0;
      rden_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
      move_q  <= move_d;
      mv_q    <= mv_d;
      rden_q  <= rden_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.col_rden   = rden_q;
  assign bus.move       = move_q;
  assign bus.move_valid = mv_q;
  assign move_count     = cnt_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_move_collector.sv
// Bench for move_collector: column FIFO model, move scoreboard, table-driven
// word patterns and hand-written abort/backpressure/ordering sequences.
module tb_move_collector;

  localparam int NCOL  = 8;
  localparam int MOVEW = 19;
  localparam int SLOTS = 8;
  localparam int WORDW = SLOTS * MOVEW;
  localparam int DEPTH = 64;

`ifdef MOVE_COLLECT_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [7:0] move_count;
  logic busy, done;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  move_collector_if #(.NCOL(NCOL), .MOVEW(MOVEW), .SLOTS(SLOTS)) bus ();

  move_collector #(.NCOL(NCOL), .MOVEW(MOVEW), .SLOTS(SLOTS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .move_count (move_count),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- column FIFO model ----------------
  logic [WORDW-1:0] mem [NCOL][DEPTH];
  int wr_ptr [NCOL];
  int rd_ptr [NCOL];

  for (genvar k = 0; k < NCOL; k++) begin : g_empty
    assign bus.col_empty[k] = (wr_ptr[k] == rd_ptr[k]);
  end

  // ---------------- scoreboard ----------------
  logic [MOVEW-1:0] exp_q [$];
  int rd_order [$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_xfer = 0;
  int rden_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sampled on the falling edge: transfers, FIFO pops and read order.
  initial begin
    logic [MOVEW-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.move_valid && bus.move_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("unexpected_move", 32'(bus.move), 32'h7FFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("move_data", 32'(bus.move), 32'(e));
        end
      end
      if (bus.col_rden != '0) begin
        rden_seen++;
        check("rden_onehot", 32'($onehot(bus.col_rden)), 32'd1);
      end
      for (int k = 0; k < NCOL; k++) begin
        if (bus.col_rden[k]) begin
          rd_order.push_back(k);
          check("rd_nonempty", 32'(wr_ptr[k] != rd_ptr[k]), 32'd1);
          bus.col_data[k*WORDW +: WORDW] = mem[k][rd_ptr[k] % DEPTH];
          rd_ptr[k] = rd_ptr[k] + 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input int col, input logic [WORDW-1:0] w);
    mem[col][wr_ptr[col] % DEPTH] = w;
    wr_ptr[col] = wr_ptr[col] + 1;
  endtask

  task automatic clear_fifos();
    for (int k = 0; k < NCOL; k++) wr_ptr[k] = rd_ptr[k];
    exp_q.delete();
    rd_order.delete();
  endtask

  function automatic logic [MOVEW-1:0] mk_move(input logic inv, input logic [5:0] flags,
                                               input logic [5:0] from, input logic [5:0] to);
    return {inv, flags, from, to};
  endfunction

  // Build one word from a valid mask and queue the moves the consumer should see.
  task automatic load_word(input int col, input logic [7:0] mask, input bit fixed_sq);
    logic [WORDW-1:0] w;
    logic [MOVEW-1:0] m;
    logic [5:0] from, to;
    w = '0;
    for (int s = 0; s < SLOTS; s++) begin
      from = fixed_sq ? 6'd12 : 6'($urandom_range(0, 63));
      to   = fixed_sq ? 6'(20 + 8*s) : 6'($urandom_range(0, 63));
      m = mk_move(!mask[s], 6'($urandom_range(0, 63)), from, to);
      w[s*MOVEW +: MOVEW] = m;
      if (!FILTER || mask[s]) exp_q.push_back(m);
    end
    push_word(col, w);
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int i;
    i = 0;
    while (n_xfer < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("xfer_wait", 32'(n_xfer >= n), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         col;
    logic [7:0] mask;
    int         nwords;
    bit         fixed_sq;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int i;
    reset = 1'b0;
    start = 1'b0;
    bus.move_ready = 1'b0;
    bus.col_done = '1;
    bus.col_data = '0;
    for (int k = 0; k < NCOL; k++) begin
      wr_ptr[k] = 0;
      rd_ptr[k] = 0;
    end

    vecs[0] = '{col: 3, mask: 8'b0000_0111, nwords: 1,  fixed_sq: 1'b1, exp_cnt: FILTER ? 3 : 8};
    vecs[1] = '{col: 0, mask: 8'hFF,        nwords: 1,  fixed_sq: 1'b0, exp_cnt: 8};
    vecs[2] = '{col: 7, mask: 8'h00,        nwords: 1,  fixed_sq: 1'b0, exp_cnt: FILTER ? 0 : 8};
    vecs[3] = '{col: 5, mask: 8'b1010_0101, nwords: 2,  fixed_sq: 1'b0, exp_cnt: FILTER ? 8 : 16};
    vecs[4] = '{col: 3, mask: 8'hFF,        nwords: 40, fixed_sq: 1'b0, exp_cnt: 255};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_move_valid", 32'(bus.move_valid), 32'd0);
    check("rst_move",       32'(bus.move),       32'd0);
    check("rst_col_rden",   32'(bus.col_rden),   32'd0);
    check("rst_count",      32'(move_count),     32'd0);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_done",       32'(done),           32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Everything already done and empty: completes with nothing read
    do_start();
    @(posedge clk); #1;
    check("empty_done",  32'(done),       32'd1);
    check("empty_count", 32'(move_count), 32'd0);
    check("empty_rden",  32'(rden_seen),  32'd0);

    // Table-driven words
    bus.move_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      clear_fifos();
      for (int w = 0; w < vecs[v].nwords; w++) load_word(vecs[v].col, vecs[v].mask, vecs[v].fixed_sq);
      do_start();
      wait_done("vec_done", 2000);
      check("vec_count", 32'(move_count), 32'(vecs[v].exp_cnt));
      check("vec_drained", 32'(exp_q.size()), 32'd0);
      check("vec_reads", 32'(rd_order.size()), 32'(vecs[v].nwords));
    end

    // Round-robin order with wrap-around
    clear_fifos();
    load_word(0, 8'hFF, 1'b0);
    load_word(5, 8'hFF, 1'b0);
    load_word(7, 8'hFF, 1'b0);
    do_start();
    i = 0;
    while (rd_order.size() < 1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    @(posedge clk); #2;
    load_word(0, 8'hFF, 1'b0);
    wait_done("rr_done", 500);
    check("rr_nreads", 32'(rd_order.size()), 32'd4);
    if (rd_order.size() == 4) begin
      check("rr_order0", 32'(rd_order[0]), 32'd0);
      check("rr_order1", 32'(rd_order[1]), 32'd5);
      check("rr_order2", 32'(rd_order[2]), 32'd7);
      check("rr_order3", 32'(rd_order[3]), 32'd0);
    end
    check("rr_count", 32'(move_count), 32'd32);

    // Backpressure on the first slot
    clear_fifos();
    bus.move_ready = 1'b0;
    load_word(2, 8'hFF, 1'b0);
    do_start();
    i = 0;
    while (!bus.move_valid && i < 20) begin
      @(negedge clk);
      i++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.move_valid), 32'd1);
      check("bp_move",  32'(bus.move),       32'(exp_q[0]));
      check("bp_count", 32'(move_count),     32'd0);
    end
    @(posedge clk); #1 bus.move_ready = 1'b1;
    wait_done("bp_done", 200);
    check("bp_final_count", 32'(move_count), 32'd8);

    // Reset mid-UNPACK
    clear_fifos();
    load_word(1, 8'hFF, 1'b0);
    load_word(1, 8'hFF, 1'b0);
    n_xfer = 0;
    do_start();
    wait_xfers(3, 100);
    @(posedge clk); #1;
    bus.move_ready = 1'b0;
    clear_fifos();
    reset = 1'b0;
    #1;
    check("rstab_valid", 32'(bus.move_valid), 32'd0);
    check("rstab_count", 32'(move_count),     32'd0);
    check("rstab_rden",  32'(bus.col_rden),   32'd0);
    check("rstab_busy",  32'(busy),           32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Start mid-UNPACK
    load_word(4, 8'hFF, 1'b0);
    load_word(4, 8'hFF, 1'b0);
    bus.move_ready = 1'b1;
    n_xfer = 0;
    do_start();
    wait_xfers(3, 100);
    @(posedge clk); #1;
    bus.move_ready = 1'b0;
    clear_fifos();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("stab_valid", 32'(bus.move_valid), 32'd0);
    check("stab_count", 32'(move_count),     32'd0);
    check("stab_rden",  32'(bus.col_rden),   32'd0);
    check("stab_busy",  32'(busy),           32'd1);
    wait_done("stab_done", 50);
    check("stab_final_count", 32'(move_count), 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
